// File: rtl/router_pkg.sv
// Shared router constants and the ingress controller state encoding.
// Build with ROUTER_FSM_DROP_EN to add the invalid-address drop state (widens the state register).
package router_pkg;

    localparam int ADDR_W = 2;
    localparam logic [ADDR_W-1:0] INVALID_ADDR = 2'b11;

`ifdef ROUTER_FSM_DROP_EN
    localparam int STATE_W = 4;
`else
    localparam int STATE_W = 3;
`endif

    // Declaration order fixes the encoding; DECODE_ADDRESS must stay first (reset value 0).
    typedef enum logic [STATE_W-1:0] {
        DECODE_ADDRESS,
        LOAD_FIRST_DATA,
        LOAD_DATA,
        LOAD_PARITY,
        CHECK_PARITY_ERROR,
        FIFO_FULL_STATE,
        LOAD_AFTER_FULL,
`ifdef ROUTER_FSM_DROP_EN
        WAIT_TILL_EMPTY,
        DROP_PACKET
`else
        WAIT_TILL_EMPTY
`endif
    } state_t;

endpackage

// File: rtl/router_fsm.sv
// Router ingress packet sequencer: Moore FSM, outputs decoded from the state register only.
// Latency: outputs follow one clk edge after the inputs; busy stalls the source. Macro ROUTER_FSM_DROP_EN adds DROP_PACKET.
// Backpressure: fifo_full parks the packet in FIFO_FULL_STATE; a busy destination holds WAIT_TILL_EMPTY.
module router_fsm
    import router_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              pkt_valid,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic              fifo_empty_0,
    input  logic              fifo_empty_1,
    input  logic              fifo_empty_2,
    input  logic              soft_reset_0,
    input  logic              soft_reset_1,
    input  logic              soft_reset_2,
    input  logic              parity_done,
    input  logic              low_pkt_valid,
    output logic              busy,
    output logic              detect_add,
    output logic              lfd_state,
    output logic              ld_state,
    output logic              laf_state,
    output logic              full_state,
    output logic              write_enb_reg,
    output logic              rst_int_reg
);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        empty_vec;
    logic [3:0]        soft_vec;
    logic              empty_in;
    logic              empty_q;
    logic              soft_q;

    // Address 3 indexes the padding bit, so it never reads as empty or soft-reset.
    assign empty_vec = {1'b0, fifo_empty_2, fifo_empty_1, fifo_empty_0};
    assign soft_vec  = {1'b0, soft_reset_2, soft_reset_1, soft_reset_0};
    assign empty_in  = empty_vec[data_in];
    assign empty_q   = empty_vec[addr_q];
    assign soft_q    = soft_vec[addr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= DECODE_ADDRESS;
            addr_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == DECODE_ADDRESS && state_nxt != DECODE_ADDRESS)
                addr_q <= data_in;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            DECODE_ADDRESS: begin
                if (pkt_valid) begin
                    if (data_in != INVALID_ADDR)
                        state_nxt = empty_in ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
`ifdef ROUTER_FSM_DROP_EN
                    else
                        state_nxt = DROP_PACKET;
`endif
                end
            end
            LOAD_FIRST_DATA:    state_nxt = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full)
                    state_nxt = FIFO_FULL_STATE;
                else if (!pkt_valid)
                    state_nxt = LOAD_PARITY;
            end
            LOAD_PARITY:        state_nxt = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: state_nxt = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            FIFO_FULL_STATE: begin
                if (!fifo_full)
                    state_nxt = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (parity_done)
                    state_nxt = DECODE_ADDRESS;
                else if (low_pkt_valid)
                    state_nxt = LOAD_PARITY;
                else
                    state_nxt = LOAD_DATA;
            end
            WAIT_TILL_EMPTY: begin
                if (empty_q)
                    state_nxt = LOAD_FIRST_DATA;
            end
`ifdef ROUTER_FSM_DROP_EN
            DROP_PACKET: begin
                if (!pkt_valid)
                    state_nxt = DECODE_ADDRESS;
            end
`endif
            default:            state_nxt = DECODE_ADDRESS;
        endcase
        // A synchronizer timeout on the active port overrides every other transition.
        if (state != DECODE_ADDRESS && soft_q)
            state_nxt = DECODE_ADDRESS;
    end

    always_comb begin
        busy          = 1'b0;
        detect_add    = 1'b0;
        lfd_state     = 1'b0;
        ld_state      = 1'b0;
        laf_state     = 1'b0;
        full_state    = 1'b0;
        write_enb_reg = 1'b0;
        rst_int_reg   = 1'b0;
        case (state)
            DECODE_ADDRESS:     detect_add = 1'b1;
            LOAD_FIRST_DATA: begin
                lfd_state = 1'b1;
                busy      = 1'b1;
            end
            LOAD_DATA: begin
                ld_state      = 1'b1;
                write_enb_reg = 1'b1;
            end
            LOAD_PARITY: begin
                busy          = 1'b1;
                write_enb_reg = 1'b1;
            end
            CHECK_PARITY_ERROR: begin
                rst_int_reg = 1'b1;
                busy        = 1'b1;
            end
            FIFO_FULL_STATE: begin
                full_state = 1'b1;
                busy       = 1'b1;
            end
            LOAD_AFTER_FULL: begin
                laf_state     = 1'b1;
                busy          = 1'b1;
                write_enb_reg = 1'b1;
            end
            WAIT_TILL_EMPTY:    busy = 1'b1;
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_router_fsm.sv
// Self-checking bench for router_fsm: directed vector table, async reset sequence, randomized run against a behavioural model.
module tb_router_fsm;
    import router_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              pkt_valid;
    logic [ADDR_W-1:0] data_in;
    logic              fifo_full;
    logic              fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic              soft_reset_0, soft_reset_1, soft_reset_2;
    logic              parity_done, low_pkt_valid;
    logic              busy, detect_add, lfd_state, ld_state, laf_state, full_state;
    logic              write_enb_reg, rst_int_reg;
    logic [7:0]        dut_out;

    router_fsm dut (
        .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .data_in(data_in), .fifo_full(fifo_full),
        .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1), .fifo_empty_2(fifo_empty_2),
        .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .busy(busy), .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .write_enb_reg(write_enb_reg),
        .rst_int_reg(rst_int_reg)
    );

    always #5 clk = ~clk;

    assign dut_out = {busy, detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg, rst_int_reg};

    // Output vectors {busy, detect_add, lfd, ld, laf, full, write_enb, rst_int}
    localparam logic [7:0] O_DEC = 8'h40, O_LFD = 8'hA0, O_LD = 8'h12, O_LP = 8'h82;
    localparam logic [7:0] O_CPE = 8'h81, O_FFS = 8'h84, O_LAF = 8'h8A, O_WTE = 8'h80, O_DROP = 8'h00;
`ifdef ROUTER_FSM_DROP_EN
    localparam logic [7:0] O_INV = O_DROP;
`else
    localparam logic [7:0] O_INV = O_DEC;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: packet phases named independently of the RTL encoding.
    localparam int P_IDLE = 0, P_FIRST = 1, P_BODY = 2, P_PARITY = 3, P_CHECK = 4;
    localparam int P_STALL = 5, P_RESUME = 6, P_WAIT = 7, P_DROP = 8;
    int m_phase = P_IDLE;
    int m_port  = 0;

    function automatic logic [7:0] m_out(input int p);
        case (p)
            P_IDLE:   return O_DEC;
            P_FIRST:  return O_LFD;
            P_BODY:   return O_LD;
            P_PARITY: return O_LP;
            P_CHECK:  return O_CPE;
            P_STALL:  return O_FFS;
            P_RESUME: return O_LAF;
            P_WAIT:   return O_WTE;
            default:  return O_DROP;
        endcase
    endfunction

    task automatic m_step();
        bit empty_sel[4];
        bit soft_sel[4];
        int nx;
        int port;
        empty_sel = '{fifo_empty_0, fifo_empty_1, fifo_empty_2, 1'b0};
        soft_sel  = '{soft_reset_0, soft_reset_1, soft_reset_2, 1'b0};
        port = int'(data_in);
        nx = m_phase;
        case (m_phase)
            P_IDLE: begin
                if (pkt_valid && port < 3) nx = empty_sel[port] ? P_FIRST : P_WAIT;
`ifdef ROUTER_FSM_DROP_EN
                else if (pkt_valid) nx = P_DROP;
`endif
            end
            P_FIRST:  nx = P_BODY;
            P_BODY:   nx = fifo_full ? P_STALL : (!pkt_valid ? P_PARITY : P_BODY);
            P_PARITY: nx = P_CHECK;
            P_CHECK:  nx = fifo_full ? P_STALL : P_IDLE;
            P_STALL:  nx = fifo_full ? P_STALL : P_RESUME;
            P_RESUME: nx = parity_done ? P_IDLE : (low_pkt_valid ? P_PARITY : P_BODY);
            P_WAIT:   nx = empty_sel[m_port] ? P_FIRST : P_WAIT;
            P_DROP:   nx = pkt_valid ? P_DROP : P_IDLE;
            default:  nx = P_IDLE;
        endcase
        if (m_phase != P_IDLE && soft_sel[m_port]) nx = P_IDLE;
        if (m_phase == P_IDLE && nx != P_IDLE) m_port = port;
        m_phase = nx;
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: outputs got %h expected %h", name, $time, got, exp);
        end
    endtask

    typedef struct {
        logic       pv;
        logic [1:0] d;
        logic       ff;
        logic [2:0] e;
        logic [2:0] sr;
        logic       pd;
        logic       lp;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic pv, input logic [1:0] d, input logic ff, input logic [2:0] e,
                               input logic [2:0] sr, input logic pd, input logic lp, input logic [7:0] exp);
        vec_t r;
        r.pv = pv; r.d = d; r.ff = ff; r.e = e; r.sr = sr; r.pd = pd; r.lp = lp; r.exp = exp;
        return r;
    endfunction

    task automatic drive(input vec_t r);
        pkt_valid = r.pv; data_in = r.d; fifo_full = r.ff;
        {fifo_empty_2, fifo_empty_1, fifo_empty_0} = r.e;
        {soft_reset_2, soft_reset_1, soft_reset_0} = r.sr;
        parity_done = r.pd; low_pkt_valid = r.lp;
    endtask

    task automatic apply(input string name, input vec_t r);
        drive(r);
        @(posedge clk);
        m_step();
        #1;
        check(name, dut_out, r.exp);
        check({name, "_model"}, dut_out, m_out(m_phase));
    endtask

    initial begin
        drive(v(0, 0, 0, 3'b000, 3'b000, 0, 0, 8'h00));
        rst = 1'b1;
        #2;
        check("reset_state", dut_out, O_DEC);
        @(posedge clk); #1;
        rst = 1'b0;
        m_phase = P_IDLE; m_port = 0;

        // normal packet to port 1
        tbl.push_back(v(1, 2'b01, 0, 3'b010, 3'b000, 0, 0, O_LFD));
        tbl.push_back(v(1, 2'b01, 0, 3'b010, 3'b000, 0, 0, O_LD));
        tbl.push_back(v(1, 2'b01, 0, 3'b010, 3'b000, 0, 0, O_LD));
        tbl.push_back(v(1, 2'b01, 0, 3'b010, 3'b000, 0, 0, O_LD));
        tbl.push_back(v(0, 2'b01, 0, 3'b010, 3'b000, 0, 0, O_LP));
        tbl.push_back(v(0, 2'b00, 0, 3'b000, 3'b000, 0, 0, O_CPE));
        tbl.push_back(v(0, 2'b00, 0, 3'b000, 3'b000, 0, 0, O_DEC));
        // busy destination 2: five wait cycles then LFD
        for (int i = 0; i < 5; i++) tbl.push_back(v(1, 2'b10, 0, 3'b000, 3'b000, 0, 0, O_WTE));
        tbl.push_back(v(1, 2'b10, 0, 3'b100, 3'b000, 0, 0, O_LFD));
        tbl.push_back(v(1, 2'b10, 0, 3'b100, 3'b000, 0, 0, O_LD));
        tbl.push_back(v(0, 2'b10, 0, 3'b100, 3'b000, 0, 0, O_LP));
        tbl.push_back(v(0, 2'b10, 0, 3'b100, 3'b000, 0, 0, O_CPE));
        tbl.push_back(v(0, 2'b10, 0, 3'b100, 3'b000, 0, 0, O_DEC));
        // full mid-packet, resume ends with low_pkt_valid
        tbl.push_back(v(1, 2'b00, 0, 3'b001, 3'b000, 0, 0, O_LFD));
        tbl.push_back(v(1, 2'b00, 0, 3'b001, 3'b000, 0, 0, O_LD));
        for (int i = 0; i < 4; i++) tbl.push_back(v(1, 2'b00, 1, 3'b001, 3'b000, 0, 0, O_FFS));
        tbl.push_back(v(1, 2'b00, 0, 3'b001, 3'b000, 0, 0, O_LAF));
        tbl.push_back(v(0, 2'b00, 0, 3'b001, 3'b000, 0, 1, O_LP));
        tbl.push_back(v(0, 2'b00, 0, 3'b001, 3'b000, 0, 0, O_CPE));
        tbl.push_back(v(0, 2'b00, 0, 3'b001, 3'b000, 0, 0, O_DEC));
        // resume ends with parity_done
        tbl.push_back(v(1, 2'b00, 0, 3'b001, 3'b000, 0, 0, O_LFD));
        tbl.push_back(v(1, 2'b00, 0, 3'b001, 3'b000, 0, 0, O_LD));
        tbl.push_back(v(1, 2'b00, 1, 3'b001, 3'b000, 0, 0, O_FFS));
        tbl.push_back(v(1, 2'b00, 0, 3'b001, 3'b000, 0, 0, O_LAF));
        tbl.push_back(v(0, 2'b00, 0, 3'b001, 3'b000, 1, 0, O_DEC));
        // resume back to LD, then full wins over pkt_valid falling
        tbl.push_back(v(1, 2'b00, 0, 3'b001, 3'b000, 0, 0, O_LFD));
        tbl.push_back(v(1, 2'b00, 0, 3'b001, 3'b000, 0, 0, O_LD));
        tbl.push_back(v(1, 2'b00, 1, 3'b001, 3'b000, 0, 0, O_FFS));
        tbl.push_back(v(1, 2'b00, 0, 3'b001, 3'b000, 0, 0, O_LAF));
        tbl.push_back(v(1, 2'b00, 0, 3'b001, 3'b000, 0, 0, O_LD));
        tbl.push_back(v(0, 2'b00, 1, 3'b001, 3'b000, 0, 0, O_FFS));
        tbl.push_back(v(0, 2'b00, 0, 3'b001, 3'b000, 0, 0, O_LAF));
        tbl.push_back(v(0, 2'b00, 0, 3'b001, 3'b000, 1, 0, O_DEC));
        // soft reset: other port ignored, own port aborts the wait
        tbl.push_back(v(1, 2'b00, 0, 3'b000, 3'b000, 0, 0, O_WTE));
        tbl.push_back(v(0, 2'b00, 0, 3'b000, 3'b010, 0, 0, O_WTE));
        tbl.push_back(v(0, 2'b00, 0, 3'b000, 3'b001, 0, 0, O_DEC));
        // soft reset ignored in DECODE; CHECK_PARITY_ERROR with full; soft reset out of FIFO_FULL
        tbl.push_back(v(1, 2'b01, 0, 3'b010, 3'b010, 0, 0, O_LFD));
        tbl.push_back(v(0, 2'b00, 0, 3'b000, 3'b000, 0, 0, O_LD));
        tbl.push_back(v(0, 2'b00, 0, 3'b000, 3'b000, 0, 0, O_LP));
        tbl.push_back(v(0, 2'b00, 1, 3'b000, 3'b000, 0, 0, O_CPE));
        tbl.push_back(v(0, 2'b00, 1, 3'b000, 3'b000, 0, 0, O_FFS));
        tbl.push_back(v(0, 2'b00, 1, 3'b000, 3'b010, 0, 0, O_DEC));
        // invalid address 11
        for (int i = 0; i < 4; i++) tbl.push_back(v(1, 2'b11, 0, 3'b111, 3'b000, 0, 0, O_INV));
        tbl.push_back(v(0, 2'b11, 0, 3'b111, 3'b000, 0, 0, O_DEC));

        foreach (tbl[i]) apply($sformatf("vec%0d", i), tbl[i]);

        // async reset between edges while in LOAD_DATA
        apply("ar_lfd", v(1, 2'b10, 0, 3'b100, 3'b000, 0, 0, O_LFD));
        apply("ar_ld", v(1, 2'b10, 0, 3'b100, 3'b000, 0, 0, O_LD));
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", dut_out, O_DEC);
        @(posedge clk); #1;
        rst = 1'b0;
        m_phase = P_IDLE; m_port = 0;
        apply("post_reset", v(0, 2'b10, 0, 3'b100, 3'b000, 0, 0, O_DEC));

        // randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            vec_t r;
            r.pv = ($urandom_range(3) != 0);
            r.d  = 2'($urandom_range(3));
            r.ff = ($urandom_range(3) == 0);
            r.e  = 3'($urandom_range(7));
            r.sr = {($urandom_range(31) == 0), ($urandom_range(31) == 0), ($urandom_range(31) == 0)};
            r.pd = ($urandom_range(4) == 0);
            r.lp = ($urandom_range(4) == 0);
            drive(r);
            @(posedge clk);
            m_step();
            #1;
            check($sformatf("rand%0d", i), dut_out, m_out(m_phase));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
